aes256_round_ctrl: RTL and testbench
====================================

AES256_ROUND_CTRL -- requirements
Module: aes256_round_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 64, max cycles dp_req may wait for dp_ack (range 2..255).
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous assert, active-high.
REQ-003 The block SHALL provide these ports:
- in_valid  in  1  request present.
- in_ready  out  1  request accepted when high with in_valid.
- in_key  in  256  cipher key.
- in_block  in  128  plaintext block.
- out_valid  out  1  result present.
- out_ready  in  1  result consumed when high with out_valid.
- out_block  out  128  ciphertext, or zero on error.
- out_err  out  1  result is a timeout error.
- abort  in  1  cancel the current operation.
- busy  out  1  state is not IDLE.
- dp_req  out  1  round request to the datapath.
- dp_ack  in  1  datapath result valid.
- dp_round  out  4  round index, 0..14.
- dp_last  out  1  dp_round==14 (no MixColumns).
- dp_state  out  128  round input state.
- dp_key  out  256  latched key, stable for the whole operation.
- dp_result  in  128  round output state.

Function
REQ-004 FSM states SHALL be IDLE, ROUND and DONE.
REQ-005 in_ready SHALL equal 1 only in IDLE with rst low; requests are never accepted in ROUND or DONE.
REQ-006 On accept (in_valid & in_ready), the block SHALL latch in_key into the key register and in_block into the state register, clear the round counter, and enter ROUND.
REQ-007 In ROUND, dp_req SHALL be 1, and dp_round, dp_state and dp_key SHALL stay stable until dp_ack.
REQ-008 On dp_ack in ROUND, the state register SHALL load dp_result; if the round is below 14 it increments and dp_req stays high the next cycle (back-to-back); if the round equals 14 the FSM enters DONE.
REQ-009 dp_ack while dp_req is low SHALL be ignored.
REQ-010 Latency: with dp_ack returned in the same cycle as each request, accept at cycle T SHALL give dp_req in cycles T+1..T+15 (15 rounds) and out_valid=1 at T+16.
REQ-011 Watchdog: it SHALL count cycles with dp_req=1 and dp_ack=0, clear on dp_ack, and hold 0 outside ROUND.
REQ-012 When the watchdog reaches TIMEOUT with no dp_ack, the FSM SHALL enter DONE with out_err=1, out_block=0 and dp_req=0.
REQ-013 In DONE, out_valid SHALL be 1, and out_block and out_err SHALL hold; out_valid & out_ready SHALL return the FSM to IDLE.
REQ-014 abort in ROUND or DONE SHALL return the FSM to IDLE at the next edge, with no output and the watchdog cleared; abort in IDLE has no effect.
REQ-015 abort SHALL take priority over a simultaneous dp_ack, timeout or out_ready.
REQ-016 Round counter width SHALL be 4 bits; it never wraps past 14.
REQ-017 busy SHALL equal (state != IDLE).

Reset
REQ-018 rst SHALL force, asynchronously: state=IDLE, round=0, watchdog=0, state/key registers=0, dp_req=0, out_valid=0, out_err=0, out_block=0, busy=0, in_ready=0.
REQ-019 Reset asserted mid-operation SHALL discard the operation; the first cycle after deassertion SHALL be IDLE with in_ready=1.

Structure
REQ-020 Package aes_ctrl_pkg SHALL hold the FSM state enum, NUM_ROUNDS=14, BLOCK_W=128 and KEY_W=256.
REQ-021 The watchdog SHALL be the sub-module aes_ctrl_watchdog (inputs: count enable, clear; output: expired).

Verification
REQ-022 FIPS-197 C.3 vector, key 000102..1f, block 00112233445566778899aabbccddeeff, zero-latency model -> out_block 8ea2b7ca516745bfeafc49904b496089, out_err=0, out_valid at accept+16.
REQ-023 Same vector, model with random ack latency 0..10 -> same ciphertext; dp_round/dp_state stable while waiting; dp_round sequence 0..14 with dp_last only at 14.
REQ-024 TIMEOUT=8, model never acks round 3 -> out_valid with out_err=1 and out_block=0 exactly 8 cycles after round-3 dp_req rises.
REQ-025 abort asserted on the same cycle as the round-7 dp_ack -> IDLE next cycle, no out_valid, and the next request produces the correct ciphertext.
REQ-026 out_ready held low for 20 cycles in DONE -> out_valid/out_block stable and in_ready=0 throughout; one cycle of out_ready -> IDLE.
REQ-027 rst pulsed asynchronously (between edges) during round 5 -> all outputs at reset values immediately; in_ready=1 in the first cycle after release.

Source files
------------

// File: rtl/aes_ctrl_pkg.sv
// aes_ctrl_pkg: shared sizes and FSM state type for the AES-256 round controller
package aes_ctrl_pkg;
  localparam int NUM_ROUNDS = 14;
  localparam int BLOCK_W = 128;
  localparam int KEY_W = 256;
  localparam int ROUND_W = 4;
  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;
endpackage

// File: rtl/aes_ctrl_watchdog.sv
// aes_ctrl_watchdog: counts stalled request cycles and flags when the limit is reached
module aes_ctrl_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expired
);
  logic [7:0] cnt;
  assign expired = en && !clr && (cnt == 8'(TIMEOUT - 1));
  // stall counter, restarted by clear or by its own expiry
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr || expired) cnt <= '0;
    else if (en) cnt <= cnt + 8'd1;
endmodule

// File: rtl/aes256_round_ctrl.sv
// aes256_round_ctrl: sequences 15 AES-256 rounds through an external datapath with timeout and abort
module aes256_round_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [KEY_W-1:0]    in_key,
  input  logic [BLOCK_W-1:0]  in_block,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BLOCK_W-1:0]  out_block,
  output logic                out_err,
  input  logic                abort,
  output logic                busy,
  output logic                dp_req,
  input  logic                dp_ack,
  output logic [ROUND_W-1:0]  dp_round,
  output logic                dp_last,
  output logic [BLOCK_W-1:0]  dp_state,
  output logic [KEY_W-1:0]    dp_key,
  input  logic [BLOCK_W-1:0]  dp_result
);
  state_t state, state_nx;
  logic [ROUND_W-1:0] round;
  logic [BLOCK_W-1:0] st;
  logic [KEY_W-1:0] key;
  logic err, accept, in_round, last, expired;
  assign in_round = state == ROUND;
  assign last = round == ROUND_W'(NUM_ROUNDS);
  assign in_ready = state == IDLE && !rst;
  assign accept = in_valid && in_ready;
  assign busy = state != IDLE;
  assign dp_req = in_round;
  assign dp_round = round;
  assign dp_last = last;
  assign dp_state = st;
  assign dp_key = key;
  assign out_valid = state == DONE;
  assign out_err = out_valid && err;
  assign out_block = (out_valid && !err) ? st : '0;
  aes_ctrl_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk(clk),
    .rst(rst),
    .en(in_round && !dp_ack),
    .clr(!in_round || dp_ack || abort),
    .expired(expired)
  );
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // next state: abort wins over ack, timeout and out_ready
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: state_nx = accept ? ROUND : IDLE;
      ROUND: state_nx = abort ? IDLE : ((dp_ack && last) || expired) ? DONE : ROUND;
      DONE: state_nx = (abort || out_ready) ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  // key/state/round registers; round saturates at the last round
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      round <= '0;
      st <= '0;
      key <= '0;
      err <= 1'b0;
    end else if (accept) begin
      round <= '0;
      st <= in_block;
      key <= in_key;
      err <= 1'b0;
    end else if (in_round && !abort) begin
      if (dp_ack) begin
        st <= dp_result;
        round <= last ? round : round + 1'b1;
      end
      err <= expired;
    end
endmodule

// File: tb/tb_aes256_round_ctrl.sv
// tb_aes256_round_ctrl: directed scoreboard bench with an AES-256 round datapath model
module tb_aes256_round_ctrl;
  import aes_ctrl_pkg::*;
  typedef struct packed {
    logic err;
    logic [127:0] blk;
  } exp_t;
  localparam logic [255:0] FKEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] FPT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FCT = 128'h8ea2b7ca516745bfeafc49904b496089;
  logic clk = 0, rst = 1;
  logic in_valid = 0, out_ready = 0, abort = 0, dp_ack = 0;
  logic [255:0] in_key = '0;
  logic [127:0] in_block = '0, dp_result = '0;
  logic in_ready, out_valid, out_err, busy, dp_req, dp_last;
  logic [127:0] out_block, dp_state;
  logic [255:0] dp_key;
  logic [3:0] dp_round;
  logic t_in_valid = 0, t_out_ready = 0, t_dp_ack = 0;
  logic [255:0] t_in_key = '0;
  logic [127:0] t_in_block = '0, t_dp_result = '0;
  logic t_in_ready, t_out_valid, t_out_err, t_busy, t_dp_req, t_dp_last;
  logic [127:0] t_out_block, t_dp_state;
  logic [255:0] t_dp_key;
  logic [3:0] t_dp_round;
  exp_t sbq[$];
  int checks = 0, failures = 0, cyc = 0, acc_cyc = 0, out_cyc = 0;
  int lat_max = 0, exp_round = 0;
  bit stray = 0;
  logic [7:0] sb[256];

  aes256_round_ctrl #(.TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_key(in_key),
    .in_block(in_block), .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
    .out_err(out_err), .abort(abort), .busy(busy), .dp_req(dp_req), .dp_ack(dp_ack),
    .dp_round(dp_round), .dp_last(dp_last), .dp_state(dp_state), .dp_key(dp_key),
    .dp_result(dp_result)
  );

  aes256_round_ctrl #(.TIMEOUT(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(t_in_valid), .in_ready(t_in_ready), .in_key(t_in_key),
    .in_block(t_in_block), .out_valid(t_out_valid), .out_ready(t_out_ready), .out_block(t_out_block),
    .out_err(t_out_err), .abort(1'b0), .busy(t_busy), .dp_req(t_dp_req), .dp_ack(t_dp_ack),
    .dp_round(t_dp_round), .dp_last(t_dp_last), .dp_state(t_dp_state), .dp_key(t_dp_key),
    .dp_result(t_dp_result)
  );

  initial forever #5 clk = ~clk;
  initial forever @(posedge clk) cyc++;
  initial begin
    #300000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "bench did not finish");
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  // round 0: AddRoundKey; 1..13: full round; 14: no MixColumns
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [255:0] k, input logic [3:0] r);
    logic [31:0] w[60];
    logic [31:0] x;
    logic [127:0] rk, t, u;
    logic [7:0] rc, a0, a1, a2, a3;
    int ri;
    rc = 8'h01;
    ri = int'(r);
    for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      x = w[i-1];
      if (i % 8 == 0) begin
        x = {sb[x[23:16]], sb[x[15:8]], sb[x[7:0]], sb[x[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (i % 8 == 4) x = {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
      w[i] = w[i-8] ^ x;
    end
    rk = {w[4*ri], w[4*ri+1], w[4*ri+2], w[4*ri+3]};
    if (ri == 0) return s ^ rk;
    for (int c = 0; c < 4; c++)
      for (int q = 0; q < 4; q++)
        t[127-8*(q+4*c) -: 8] = sb[s[127-8*(q+4*((c+q)%4)) -: 8]];
    if (ri == 14) return t ^ rk;
    for (int c = 0; c < 4; c++) begin
      a0 = t[127-32*c -: 8];
      a1 = t[119-32*c -: 8];
      a2 = t[111-32*c -: 8];
      a3 = t[103-32*c -: 8];
      u[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3, a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3, xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    return u ^ rk;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [255:0] k, input logic [127:0] p);
    logic [127:0] s;
    s = p;
    for (int r = 0; r <= 14; r++) s = aes_round(s, k, 4'(r));
    return s;
  endfunction

  // datapath model for dut: acks after 0..lat_max wait cycles, checks hold and round order
  initial begin
    int wcnt, wtgt;
    bit waiting;
    logic [3:0] s_round;
    logic [127:0] s_state;
    logic [255:0] s_key;
    waiting = 0;
    wcnt = 0;
    wtgt = 0;
    forever begin
      @(negedge clk);
      if (dp_req) begin
        if (!waiting) begin
          waiting = 1;
          wcnt = 0;
          wtgt = lat_max > 0 ? int'($urandom_range(lat_max, 0)) : 0;
          s_round = dp_round;
          s_state = dp_state;
          s_key = dp_key;
        end else chk("dp_hold", {dp_round, dp_state, dp_key}, {s_round, s_state, s_key});
        if (wcnt == wtgt) begin
          dp_ack = 1;
          dp_result = aes_round(dp_state, dp_key, dp_round);
          waiting = 0;
          chk("dp_round_seq", dp_round, exp_round);
          chk("dp_last", dp_last, exp_round == 14);
          exp_round++;
        end else begin
          dp_ack = 0;
          dp_result = {$urandom, $urandom, $urandom, $urandom};
          wcnt++;
        end
      end else begin
        waiting = 0;
        dp_ack = stray;
        dp_result = {$urandom, $urandom, $urandom, $urandom};
      end
    end
  end

  // datapath model for dut8: immediate ack except round 3, which never completes
  initial forever begin
    @(negedge clk);
    t_dp_ack = t_dp_req && t_dp_round != 4'd3;
    t_dp_result = aes_round(t_dp_state, t_dp_key, t_dp_round);
  end

  task automatic start_op(input logic [255:0] k, input logic [127:0] p, input exp_t e);
    @(posedge clk);
    #1;
    exp_round = 0;
    in_valid = 1;
    in_key = k;
    in_block = p;
    @(negedge clk);
    chk("accept_ready", in_ready, 1);
    acc_cyc = cyc;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 0;
  endtask

  task automatic wait_out(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < budget);
    chk({tag, "_out_valid"}, out_valid, 1);
    out_cyc = cyc;
  endtask

  task automatic pop_chk(input string tag, input logic err, input logic [127:0] blk);
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk({tag, "_blk"}, blk, e.blk);
      chk({tag, "_err"}, err, e.err);
    end
  endtask

  task automatic consume();
    @(posedge clk);
    #1;
    out_ready = 1;
    @(posedge clk);
    #1;
    out_ready = 0;
    chk("consume_idle", {busy, in_ready, out_valid}, 3'b010);
  endtask

  initial begin
    int n, r3;
    logic [255:0] k;
    logic [127:0] p;
    for (int i = 0; i < 256; i++) sb[i] = sbox_calc(8'(i));
    #1;
    chk("rst_ctrl", {in_ready, busy, dp_req, out_valid, out_err}, 5'b0);
    chk("rst_data", {dp_round, dp_state, out_block}, 0);
    chk("rst_key", dp_key, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("idle_ready", {in_ready, busy}, 2'b10);
    stray = 1;
    repeat (3) @(negedge clk);
    chk("stray_ack_idle", {busy, dp_req, out_valid}, 3'b000);
    stray = 0;
    // FIPS-197 C.3, zero-latency datapath
    start_op(FKEY, FPT, exp_t'({1'b0, FCT}));
    wait_out("fips0", 30);
    chk("fips0_latency", out_cyc - acc_cyc, 16);
    pop_chk("fips0", out_err, out_block);
    consume();
    // same vector, random ack latency
    lat_max = 10;
    start_op(FKEY, FPT, exp_t'({1'b0, FCT}));
    wait_out("fips_rand", 400);
    pop_chk("fips_rand", out_err, out_block);
    consume();
    // random vector, random latency
    for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
    for (int i = 0; i < 4; i++) p[32*i +: 32] = $urandom;
    start_op(k, p, exp_t'({1'b0, aes_enc(k, p)}));
    wait_out("rand_vec", 400);
    pop_chk("rand_vec", out_err, out_block);
    consume();
    // abort on the round-7 ack
    lat_max = 0;
    start_op(FKEY, FPT, exp_t'({1'b0, FCT}));
    n = 0;
    while (dp_round != 4'd7 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("abort_at7", dp_round, 7);
    abort = 1;
    @(posedge clk);
    #1;
    abort = 0;
    chk("abort_idle", {busy, in_ready, dp_req, out_valid}, 4'b0100);
    sbq.delete(0);
    repeat (4) begin
      @(negedge clk);
      chk("abort_no_out", out_valid, 0);
    end
    // abort in IDLE is ignored: request is still accepted and completes
    @(posedge clk);
    #1;
    exp_round = 0;
    in_valid = 1;
    abort = 1;
    in_key = FKEY;
    in_block = FPT;
    sbq.push_back(exp_t'({1'b0, FCT}));
    @(posedge clk);
    #1;
    in_valid = 0;
    abort = 0;
    chk("idle_abort_ignored", busy, 1);
    wait_out("post_abort", 30);
    pop_chk("post_abort", out_err, out_block);
    consume();
    // DONE held with out_ready low; stray acks must not disturb the result
    start_op(FKEY, FPT, exp_t'({1'b0, FCT}));
    wait_out("hold", 30);
    stray = 1;
    in_valid = 1;
    repeat (20) begin
      @(negedge clk);
      chk("hold_done", {out_valid, in_ready, out_err, out_block}, {3'b100, FCT});
    end
    stray = 0;
    in_valid = 0;
    pop_chk("hold", out_err, out_block);
    consume();
    // watchdog on dut8 (TIMEOUT=8), round 3 never acked
    @(posedge clk);
    #1;
    t_in_valid = 1;
    t_in_key = FKEY;
    t_in_block = FPT;
    @(negedge clk);
    chk("t_accept", t_in_ready, 1);
    sbq.push_back(exp_t'({1'b1, 128'h0}));
    @(posedge clk);
    #1;
    t_in_valid = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(t_dp_req && t_dp_round == 4'd3) && n < 20);
    chk("t_round3_req", {t_dp_req, t_dp_round}, {1'b1, 4'd3});
    r3 = cyc;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!t_out_valid && n < 40);
    chk("t_timeout_latency", cyc - r3, 8);
    chk("t_done_ctrl", {t_out_valid, t_dp_req, t_busy}, 3'b101);
    pop_chk("t_timeout", t_out_err, t_out_block);
    @(posedge clk);
    #1;
    t_out_ready = 1;
    @(posedge clk);
    #1;
    t_out_ready = 0;
    chk("t_idle", {t_busy, t_in_ready}, 2'b01);
    // asynchronous reset pulse during round 5
    start_op(FKEY, FPT, exp_t'({1'b0, FCT}));
    n = 0;
    while (dp_round != 4'd5 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("arst_at5", {dp_req, dp_round}, {1'b1, 4'd5});
    @(negedge clk);
    #2;
    rst = 1;
    #1;
    chk("arst_ctrl", {in_ready, busy, dp_req, out_valid, out_err}, 5'b0);
    chk("arst_data", {dp_round, dp_state, out_block}, 0);
    chk("arst_key", dp_key, 0);
    #1;
    rst = 0;
    sbq.delete(0);
    @(negedge clk);
    chk("arst_release", {in_ready, busy, out_valid}, 3'b100);
    chk("sb_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
